vga_raster_engine: RTL
======================

# vga_raster_engine

Parametrised second-generation VGA raster engine for the display path of the SLAM map viewer. It generates programmable H/V timing, issues per-pixel fetch requests (x, y, linear framebuffer address) to the map memory, and absorbs a fixed fetch latency through an internal alignment pipeline. It adds built-in test patterns, frame/line/vblank event pulses, and clean start/stop at frame boundaries. It sits between the framebuffer read port and the VGA pins.

## Interface
Parameters:
- FRAME_WIDTH, 1600, active pixels per line
- FRAME_HEIGHT, 900, active lines per frame
- H_FP / H_PW / H_MAX, 24 / 80 / 1800, H front porch, sync width, total (pixels)
- V_FP / V_PW / V_MAX, 1 / 3 / 1000, V front porch, sync width, total (lines)
- H_POL / V_POL, 0 / 0, asserted sync level
- COLOR_BITS, 4, bits per colour channel
- LATENCY, 2, cycles from request to rgb_in valid (≥1)
- CHK_LOG2, 4, checkerboard square size = 2^CHK_LOG2 pixels
- Derived: HW=$clog2(H_MAX), VW=$clog2(V_MAX), AW=$clog2(FRAME_WIDTH*FRAME_HEIGHT), CW=3*COLOR_BITS

Ports:
- clock  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- enable  in  1  run request
- mode  in  2  0 external, 1 colour bars, 2 checkerboard, 3 solid black
- rgb_in  in  CW  fetched pixel {r,g,b}, valid LATENCY cycles after its request
- req_valid  out  1  fetch request for current pixel
- req_x / req_y  out  HW / VW  raster counters
- req_addr  out  AW  y*FRAME_WIDTH + x
- vgaRed / vgaGreen / vgaBlue  out  COLOR_BITS each
- Hsync / Vsync  out  1
- de  out  1  output pixel active
- frame_start / line_start / vblank_irq  out  1  single-cycle event pulses
- busy  out  1  state ≠ IDLE

## Operation
- Counters: x wraps at H_MAX-1, y increments on x wrap, wraps at V_MAX-1; count only in RUN/DRAIN.
- active = x<FRAME_WIDTH && y<FRAME_HEIGHT; req_valid = active && mode==0 && state≠IDLE.
- req_addr: running register, +1 on each active pixel, cleared when (x,y) wraps to (0,0); equals y*FRAME_WIDTH+x whenever req_valid.
- Hsync = H_POL for x in [FRAME_WIDTH+H_FP, FRAME_WIDTH+H_FP+H_PW-1]; Vsync = V_POL for y in [FRAME_HEIGHT+V_FP, FRAME_HEIGHT+V_FP+V_PW-1], whole lines.
- State machine: IDLE → RUN when enable=1 (counters (0,0) in first RUN cycle). RUN → DRAIN when enable=0. DRAIN → RUN when enable=1. DRAIN at (H_MAX-1,V_MAX-1) → IDLE; RUN there wraps. Frames are never truncated.
- Mode sampled at counter stage when (x,y)=(0,0); held for the whole frame.
- Patterns (computed at counter stage): bars: index 0..7 advances every FRAME_WIDTH/8 pixels (small counter, no divider), {r,g,b} = index bits {2,1,0} each at full scale; checker: white if x[CHK_LOG2]^y[CHK_LOG2], else black; mode 3 all-zero.
- Events generated at counter stage: frame_start at (0,0); line_start at x=0 of active lines; vblank_irq at (0,FRAME_HEIGHT).
- Parameter illegal if FRAME_WIDTH+H_FP+H_PW > H_MAX or the V equivalent (elaboration error).

## Timing
- Alignment pipeline of LATENCY stages carries {Hsync,Vsync,active,events,pattern pixel,mode}; final register samples rgb_in (mode 0) or pattern pixel. All pin outputs appear LATENCY+1 cycles after their counter value.
- Colour outputs 0 whenever de=0.
- In IDLE the pipeline keeps shifting inactive values, so the last frame drains completely.
- Reset (reset=0, any cycle incl. mid-frame): next edge state IDLE, counters/addr 0, pipeline cleared, Hsync=~H_POL, Vsync=~V_POL, de=0, colours 0, pulses 0, busy=0, req_valid=0.

## Structure
- Package vga_pkg: mode constants, state encoding, pattern colour constants, sync-window helper functions.
- Sub-module vga_delay_line (WIDTH, DEPTH, synchronous active-low clear) for the alignment pipeline.

## Test plan
Small config: FRAME_WIDTH=8, H_FP=2, H_PW=2, H_MAX=16, FRAME_HEIGHT=4, V_FP=1, V_PW=1, V_MAX=8, LATENCY=2.
- Reset then enable=1, mode=0, rgb_in = delayed req_addr -> de high 8 of 16 cycles per line for 4 lines; first de cycle 3 cycles after first RUN cycle, colours = 0; Hsync low x=10..11, Vsync low line 5 (output-aligned).
- req_addr over one frame -> 0..31 in order, only while req_valid; resets to 0 next frame.
- mode=1 -> bar index changes every pixel; pixel 5 output {r,g,b}={F,0,F}; mode change mid-frame takes effect next frame only.
- enable dropped at (3,2) -> busy stays 1 until (15,7) completes, then IDLE; outputs drain 3 cycles; re-enable in DRAIN -> continues without gap.
- reset=0 at (6,1) -> next cycle all outputs at reset values, busy=0.
- Pulses over two frames -> exactly 2 frame_start, 8 line_start, 2 vblank_irq, each one cycle wide.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, constants and helpers for the VGA raster engine.
package vga_pkg;

  typedef enum logic [1:0] {
    ModeExt     = 2'd0,
    ModeBars    = 2'd1,
    ModeChecker = 2'd2,
    ModeBlack   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Pattern colours as {r,g,b} channel masks, expanded to full scale per channel.
  localparam logic [2:0] PatBlack = 3'b000;
  localparam logic [2:0] PatWhite = 3'b111;

  function automatic logic in_window(int unsigned pos, int unsigned lo, int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_raster_engine_if.sv
// Framebuffer fetch port: per-pixel request out, fetched pixel back LATENCY cycles later.
interface vga_raster_engine_if #(
  parameter int unsigned HW = 11,
  parameter int unsigned VW = 10,
  parameter int unsigned AW = 21,
  parameter int unsigned CW = 12
) ();

  logic          req_valid;
  logic [HW-1:0] req_x;
  logic [VW-1:0] req_y;
  logic [AW-1:0] req_addr;
  logic [CW-1:0] rgb_in;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    output req_addr,
    input  rgb_in
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  req_addr,
    output rgb_in
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_raster_engine.sv
// VGA raster engine: timing counters, fetch requests, test patterns and a
// latency-matched pipeline to the output pins.
module vga_raster_engine
  import vga_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 1600,
  parameter int unsigned FRAME_HEIGHT = 900,
  parameter int unsigned H_FP         = 24,
  parameter int unsigned H_PW         = 80,
  parameter int unsigned H_MAX        = 1800,
  parameter int unsigned V_FP         = 1,
  parameter int unsigned V_PW         = 3,
  parameter int unsigned V_MAX        = 1000,
  parameter bit          H_POL        = 1'b0,
  parameter bit          V_POL        = 1'b0,
  parameter int unsigned COLOR_BITS   = 4,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned CHK_LOG2     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  vga_raster_engine_if.master   fetch,
  output logic [COLOR_BITS-1:0] vgaRed,
  output logic [COLOR_BITS-1:0] vgaGreen,
  output logic [COLOR_BITS-1:0] vgaBlue,
  output logic                  Hsync,
  output logic                  Vsync,
  output logic                  de,
  output logic                  frame_start,
  output logic                  line_start,
  output logic                  vblank_irq,
  output logic                  busy
);

  localparam int unsigned HW    = $clog2(H_MAX);
  localparam int unsigned VW    = $clog2(V_MAX);
  localparam int unsigned AW    = $clog2(FRAME_WIDTH * FRAME_HEIGHT);
  localparam int unsigned CW    = 3 * COLOR_BITS;
  localparam int unsigned BAR_W = (FRAME_WIDTH >= 8) ? FRAME_WIDTH / 8 : 1;
  localparam int unsigned BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  if (FRAME_WIDTH + H_FP + H_PW > H_MAX) begin : g_bad_h
    $error("vga_raster_engine: horizontal blanking does not fit in H_MAX");
  end
  if (FRAME_HEIGHT + V_FP + V_PW > V_MAX) begin : g_bad_v
    $error("vga_raster_engine: vertical blanking does not fit in V_MAX");
  end
  if (LATENCY < 1) begin : g_bad_lat
    $error("vga_raster_engine: LATENCY must be at least 1");
  end

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          active;
    logic          fs;
    logic          ls;
    logic          vb;
    logic          ext;
    logic [CW-1:0] pix;
  } stage_t;

  state_e          state_q, state_d;
  logic            running;
  logic [HW-1:0]   x_q, x_d;
  logic [VW-1:0]   y_q, y_d;
  logic [AW-1:0]   addr_q, addr_d;
  mode_e           mode_q, mode_d, mode_cur;
  logic [BCW-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic            x_last, y_last, frame_end, origin, active;
  logic [2:0]      pat_mask;
  stage_t          pipe_in, pipe_out;

  logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic                  fs_q, fs_d, ls_q, ls_d, vb_q, vb_d;
  logic [CW-1:0]         rgb_q, rgb_d;

  assign x_last    = (x_q == HW'(H_MAX - 1));
  assign y_last    = (y_q == VW'(V_MAX - 1));
  assign frame_end = x_last && y_last;
  assign origin    = (x_q == '0) && (y_q == '0);
  assign active    = running && (x_q < HW'(FRAME_WIDTH)) && (y_q < VW'(FRAME_HEIGHT));
  // The frame's mode is latched at (0,0) but must already apply to that first pixel.
  assign mode_cur  = origin ? mode_e'(mode) : mode_q;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state; stopping only ever happens on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = frame_end ? StIdle : StDrain;
      StDrain: begin
        if (enable)         state_d = StRun;
        else if (frame_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running = (state_q != StIdle);
    busy    = running;
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (running) begin
      mode_d = mode_cur;
      x_d    = x_last ? '0 : x_q + 1'b1;
      if (x_last) y_d = y_last ? '0 : y_q + 1'b1;
      if (frame_end)   addr_d = '0;
      else if (active) addr_d = addr_q + 1'b1;
      if (x_last) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (active) begin
        if (bar_cnt_q == BCW'(BAR_W - 1)) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 1'b1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      mode_q    <= ModeExt;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  always_comb begin
    pat_mask = PatBlack;
    unique case (mode_cur)
      ModeBars:    pat_mask = bar_idx_q;
      ModeChecker: pat_mask = (1'(x_q >> CHK_LOG2) ^ 1'(y_q >> CHK_LOG2)) ? PatWhite : PatBlack;
      default:     pat_mask = PatBlack;
    endcase
  end

  assign fetch.req_valid = active && (mode_cur == ModeExt);
  assign fetch.req_x     = x_q;
  assign fetch.req_y     = y_q;
  assign fetch.req_addr  = addr_q;

  // Sync flags travel as "asserted" so a cleared pipeline means inactive sync.
  always_comb begin
    pipe_in.hs     = running && in_window(32'(x_q), FRAME_WIDTH + H_FP, H_PW);
    pipe_in.vs     = running && in_window(32'(y_q), FRAME_HEIGHT + V_FP, V_PW);
    pipe_in.active = active;
    pipe_in.fs     = running && origin;
    pipe_in.ls     = running && (x_q == '0) && (y_q < VW'(FRAME_HEIGHT));
    pipe_in.vb     = running && (x_q == '0) && (y_q == VW'(FRAME_HEIGHT));
    pipe_in.ext    = (mode_cur == ModeExt);
    pipe_in.pix    = {{COLOR_BITS{pat_mask[2]}}, {COLOR_BITS{pat_mask[1]}},
                      {COLOR_BITS{pat_mask[0]}}};
  end

  vga_delay_line #(
    .WIDTH ($bits(stage_t)),
    .DEPTH (LATENCY)
  ) u_align (
    .clk_i  (clock),
    .clr_ni (reset),
    .d_i    (pipe_in),
    .q_o    (pipe_out)
  );

  always_comb begin
    hsync_d = pipe_out.hs ? H_POL : ~H_POL;
    vsync_d = pipe_out.vs ? V_POL : ~V_POL;
    de_d    = pipe_out.active;
    fs_d    = pipe_out.fs;
    ls_d    = pipe_out.ls;
    vb_d    = pipe_out.vb;
    rgb_d   = '0;
    if (pipe_out.active) rgb_d = pipe_out.ext ? fetch.rgb_in : pipe_out.pix;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      vb_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      vb_q    <= vb_d;
      rgb_q   <= rgb_d;
    end
  end

  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign vblank_irq  = vb_q;
  assign vgaRed      = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign vgaGreen    = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign vgaBlue     = rgb_q[COLOR_BITS-1:0];

endmodule
